// File: rtl/apple1_pia_pkg.sv
// apple1_pia_pkg
//   Shared constants for the Apple-1 PIA keyboard/display block:
//   register offsets within $D010-$D013 and the ASCII case-folding constants
//   applied to incoming keystrokes.
package apple1_pia_pkg;

    localparam logic [1:0] REG_KBD   = 2'd0;
    localparam logic [1:0] REG_KBDCR = 2'd1;
    localparam logic [1:0] REG_DSP   = 2'd2;
    localparam logic [1:0] REG_DSPCR = 2'd3;

    localparam logic [6:0] ASCII_LC_A  = 7'h61;
    localparam logic [6:0] ASCII_LC_Z  = 7'h7A;
    localparam logic [6:0] CASE_OFFSET = 7'h20;

    // Fold lowercase letters to uppercase; the Apple-1 monitor only knows uppercase.
    function automatic logic [6:0] to_upper(input logic [6:0] c);
        if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) begin
            return c - CASE_OFFSET;
        end
        return c;
    endfunction

endpackage

// File: rtl/apple1_pia_fifo.sv
// apple1_pia_fifo
//   Synchronous FIFO used to buffer host keystrokes.
//   Ports:
//     clk, reset        clock and synchronous active-high reset
//     push, wdata       write request and data (ignored while full)
//     pop               read request (ignored while empty)
//     rdata             current head entry (valid when ~empty)
//     full, empty       occupancy flags, derived from the registered count
//     count             number of stored entries
module apple1_pia_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// apple1_pia
//   Apple-1 PIA replacement at $D010-$D013: keyboard FIFO with uppercase
//   folding, and a one-deep display character register handed out over
//   valid/ready.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     enable, cs, addr, din, we  CPU bus access (qualified by enable & cs)
//     dout                       register read data (combinational from addr)
//     kbd_data/valid/ready       host keystroke input handshake
//     dsp_data/valid/ready       display character output handshake
//     irq_n                      active-low keyboard interrupt
//   Build option: define PIA_IRQ_EN to drive irq_n from KBDCR bit 0 and the
//   FIFO state; otherwise irq_n is tied high.
module apple1_pia
    import apple1_pia_pkg::*;
#(
    parameter int KBD_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    input  logic       we,
    output logic [7:0] dout,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [7:0] dsp_data,
    output logic       dsp_valid,
    input  logic       dsp_ready,
    output logic       irq_n
);

    logic       acc, wr, rd;
    logic       kbd_push, kbd_pop;
    logic       kbd_full, kbd_empty;
    logic [6:0] kbd_head;
    logic [$clog2(KBD_DEPTH):0] kbd_count;

    logic [6:0] ctrl_k_q, ctrl_k_d;
    logic [6:0] ctrl_d_q, ctrl_d_d;
    logic [6:0] last_dsp_q, last_dsp_d;
    logic [7:0] dsp_data_q, dsp_data_d;
    logic       dsp_valid_q, dsp_valid_d;
    logic       dsp_load;

    logic unused_bits;
    assign unused_bits = ^{din[7], kbd_data[7], kbd_count};

    assign acc = enable & cs;
    assign wr  = acc & we;
    assign rd  = acc & ~we;

    assign kbd_ready = ~kbd_full;
    assign kbd_push  = kbd_valid & kbd_ready;
    assign kbd_pop   = rd & (addr == REG_KBD) & ~kbd_empty;

    apple1_pia_fifo #(
        .WIDTH (7),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kbd_push),
        .pop   (kbd_pop),
        .wdata (to_upper(kbd_data[6:0])),
        .rdata (kbd_head),
        .full  (kbd_full),
        .empty (kbd_empty),
        .count (kbd_count)
    );

    always_comb begin
        dout = 8'h00;
        case (addr)
            REG_KBD:   dout = kbd_empty ? 8'h00 : {1'b1, kbd_head};
            REG_KBDCR: dout = {~kbd_empty, ctrl_k_q};
            REG_DSP:   dout = {dsp_valid_q, last_dsp_q};
            REG_DSPCR: dout = {1'b0, ctrl_d_q};
            default:   dout = 8'h00;
        endcase
    end

    // A DSP write is taken when the slot is free or is being drained this cycle.
    assign dsp_load = wr & (addr == REG_DSP) & (~dsp_valid_q | dsp_ready);

    always_comb begin
        ctrl_k_d    = ctrl_k_q;
        ctrl_d_d    = ctrl_d_q;
        last_dsp_d  = last_dsp_q;
        dsp_data_d  = dsp_data_q;
        dsp_valid_d = dsp_valid_q;
        if (wr && (addr == REG_KBDCR)) begin
            ctrl_k_d = din[6:0];
        end
        if (wr && (addr == REG_DSPCR)) begin
            ctrl_d_d = din[6:0];
        end
        if (dsp_load) begin
            dsp_data_d  = {1'b0, din[6:0]};
            last_dsp_d  = din[6:0];
            dsp_valid_d = 1'b1;
        end else if (dsp_valid_q && dsp_ready) begin
            dsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_k_q    <= '0;
            ctrl_d_q    <= '0;
            last_dsp_q  <= '0;
            dsp_data_q  <= 8'h00;
            dsp_valid_q <= 1'b0;
        end else begin
            ctrl_k_q    <= ctrl_k_d;
            ctrl_d_q    <= ctrl_d_d;
            last_dsp_q  <= last_dsp_d;
            dsp_data_q  <= dsp_data_d;
            dsp_valid_q <= dsp_valid_d;
        end
    end

    assign dsp_data  = dsp_data_q;
    assign dsp_valid = dsp_valid_q;

`ifdef PIA_IRQ_EN
    logic irq_n_q, irq_n_d;

    // Follows the registered FIFO state, so it releases one cycle after the emptying pop.
    assign irq_n_d = ~(ctrl_k_q[0] & ~kbd_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`else
    assign irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_apple1_pia.sv
module tb_apple1_pia;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, enable, cs, we, kbd_valid, dsp_ready;
    logic [1:0] addr;
    logic [7:0] din, kbd_data;
    logic [7:0] dout, dsp_data;
    logic       kbd_ready, dsp_valid, irq_n;

    int checks = 0;
    int errors = 0;

    apple1_pia #(.KBD_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cs        (cs),
        .addr      (addr),
        .din       (din),
        .we        (we),
        .dout      (dout),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready),
        .irq_n     (irq_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic c, input logic w,
                         input logic [1:0] a, input logic [7:0] d, input logic kv,
                         input logic [7:0] kd, input logic dr);
        reset = rst; enable = en; cs = c; we = w; addr = a; din = d;
        kbd_valid = kv; kbd_data = kd; dsp_ready = dr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [6:0] m_q[$];
    logic [6:0] m_ctrl_k, m_ctrl_d, m_last, m_dsp_char;
    logic       m_dsp_valid, m_irq_n;

    function automatic logic [7:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0:    return (m_q.size() == 0) ? 8'h00 : {1'b1, m_q[0]};
            2'd1:    return {(m_q.size() != 0), m_ctrl_k};
            2'd2:    return {m_dsp_valid, m_last};
            default: return {1'b0, m_ctrl_d};
        endcase
    endfunction

    task automatic m_reset;
        m_q.delete();
        m_ctrl_k = 0; m_ctrl_d = 0; m_last = 0; m_dsp_char = 0;
        m_dsp_valid = 0; m_irq_n = 1;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic m_step;
        logic access, rd_a, wr_a, nonempty, room;
        logic [6:0] ch;
        if (reset) begin
            m_reset();
            return;
        end
        access   = enable & cs;
        rd_a     = access & ~we;
        wr_a     = access & we;
        nonempty = (m_q.size() > 0);
        room     = (m_q.size() < DEPTH);
`ifdef PIA_IRQ_EN
        m_irq_n = !(m_ctrl_k[0] && nonempty);
`else
        m_irq_n = 1'b1;
`endif
        if (wr_a && addr == 2'd2 && (!m_dsp_valid || dsp_ready)) begin
            m_dsp_char  = din[6:0];
            m_last      = din[6:0];
            m_dsp_valid = 1'b1;
        end else if (m_dsp_valid && dsp_ready) begin
            m_dsp_valid = 1'b0;
        end
        if (wr_a && addr == 2'd1) m_ctrl_k = din[6:0];
        if (wr_a && addr == 2'd3) m_ctrl_d = din[6:0];
        if (rd_a && addr == 2'd0 && nonempty) void'(m_q.pop_front());
        if (kbd_valid && room) begin
            ch = kbd_data[6:0];
            if (ch >= 7'h61 && ch <= 7'h7A) ch = ch - 7'h20;
            m_q.push_back(ch);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       en, c, w;
        bit [1:0] a;
        bit [7:0] d;
        bit       kv;
        bit [7:0] kd;
        bit       dr;
        bit [7:0] e_dout;
        bit       e_kr, e_dv;
        bit [7:0] e_dd;
    } vec_t;

    vec_t vecs[22];

    initial begin
        logic [7:0] keys[5];
        logic [7:0] pops[4];

        vecs[0]  = '{1,1,0,2'd0,8'h00,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[1]  = '{1,1,0,2'd1,8'h00,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[2]  = '{1,1,0,2'd2,8'h00,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[3]  = '{1,1,0,2'd3,8'h00,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[4]  = '{0,0,0,2'd0,8'h00,1,8'h61,0, 8'h00,1,0,8'h00};
        vecs[5]  = '{1,1,0,2'd1,8'h00,0,8'h00,0, 8'h80,1,0,8'h00};
        vecs[6]  = '{1,1,0,2'd0,8'h00,0,8'h00,0, 8'hC1,1,0,8'h00};
        vecs[7]  = '{1,1,0,2'd1,8'h00,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[8]  = '{1,1,1,2'd2,8'h8D,0,8'h00,0, 8'h00,1,0,8'h00};
        vecs[9]  = '{1,1,0,2'd2,8'h00,0,8'h00,0, 8'h8D,1,1,8'h0D};
        vecs[10] = '{1,1,1,2'd2,8'h41,0,8'h00,0, 8'h8D,1,1,8'h0D};
        vecs[11] = '{0,0,0,2'd2,8'h00,0,8'h00,1, 8'h8D,1,1,8'h0D};
        vecs[12] = '{1,1,0,2'd2,8'h00,0,8'h00,0, 8'h0D,1,0,8'h00};
        vecs[13] = '{1,1,1,2'd2,8'h52,0,8'h00,0, 8'h0D,1,0,8'h00};
        vecs[14] = '{1,1,1,2'd2,8'h53,0,8'h00,1, 8'hD2,1,1,8'h52};
        vecs[15] = '{1,1,0,2'd2,8'h00,0,8'h00,0, 8'hD3,1,1,8'h53};
        vecs[16] = '{1,1,1,2'd3,8'hFF,0,8'h00,0, 8'h00,1,1,8'h53};
        vecs[17] = '{1,1,0,2'd3,8'h00,0,8'h00,0, 8'h7F,1,1,8'h53};
        vecs[18] = '{1,1,1,2'd1,8'h81,0,8'h00,0, 8'h00,1,1,8'h53};
        vecs[19] = '{1,1,0,2'd1,8'h00,0,8'h00,0, 8'h01,1,1,8'h53};
        vecs[20] = '{1,0,1,2'd0,8'h55,0,8'h00,0, 8'h00,1,1,8'h53};
        vecs[21] = '{1,1,0,2'd0,8'h00,0,8'h00,0, 8'h00,1,1,8'h53};

        drive(1, 0,0,0, 2'd0, 8'h00, 0, 8'h00, 0);
        tick(); tick();

        // Directed table (registers, push/pop, display handshake)
        for (int i = 0; i < 22; i++) begin
            drive(0, vecs[i].en, vecs[i].c, vecs[i].w, vecs[i].a, vecs[i].d,
                  vecs[i].kv, vecs[i].kd, vecs[i].dr);
            @(negedge clk);
            chk($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
            chk($sformatf("vec%0d kbd_ready", i), {7'd0, kbd_ready}, {7'd0, vecs[i].e_kr});
            chk($sformatf("vec%0d dsp_valid", i), {7'd0, dsp_valid}, {7'd0, vecs[i].e_dv});
            if (vecs[i].e_dv) chk($sformatf("vec%0d dsp_data", i), dsp_data, vecs[i].e_dd);
            chk($sformatf("vec%0d irq_n", i), {7'd0, irq_n}, 8'h01);
            tick();
        end

        // FIFO fill, hold when full, same-cycle pop does not raise kbd_ready
        keys = '{8'h68, 8'h69, 8'h4A, 8'h6B, 8'h6C};
        pops = '{8'hC9, 8'hCA, 8'hCB, 8'hCC};
        drive(1, 0,0,0, 2'd0, 8'h00, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0,0,0, 2'd0, 8'h00, 1, keys[i], 0);
            @(negedge clk);
            chk($sformatf("fill%0d kbd_ready", i), {7'd0, kbd_ready}, 8'h01);
            tick();
        end
        drive(0, 0,0,0, 2'd0, 8'h00, 1, keys[4], 0);
        @(negedge clk);
        chk("full kbd_ready", {7'd0, kbd_ready}, 8'h00);
        tick();
        @(negedge clk);
        chk("held kbd_ready", {7'd0, kbd_ready}, 8'h00);
        tick();
        drive(0, 1,1,0, 2'd0, 8'h00, 1, keys[4], 0);
        @(negedge clk);
        chk("pop-cycle kbd_ready", {7'd0, kbd_ready}, 8'h00);
        chk("pop0 dout", dout, 8'hC8);
        tick();
        drive(0, 0,0,0, 2'd0, 8'h00, 1, keys[4], 0);
        @(negedge clk);
        chk("after-pop kbd_ready", {7'd0, kbd_ready}, 8'h01);
        tick();
        drive(0, 0,0,0, 2'd0, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        chk("refull kbd_ready", {7'd0, kbd_ready}, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1,1,0, 2'd0, 8'h00, 0, 8'h00, 0);
            @(negedge clk);
            chk($sformatf("pop%0d dout", i + 1), dout, pops[i]);
            tick();
        end
        @(negedge clk);
        chk("drained KBD", dout, 8'h00);
        chk("drained kbd_ready", {7'd0, kbd_ready}, 8'h01);
        tick();

        // Interrupt on key with KBDCR bit 0 set
        drive(0, 1,1,1, 2'd1, 8'h01, 0, 8'h00, 0); tick();
        drive(0, 0,0,0, 2'd0, 8'h00, 1, 8'h41, 0); tick();
        drive(0, 0,0,0, 2'd0, 8'h00, 0, 8'h00, 0); tick();
        @(negedge clk);
`ifdef PIA_IRQ_EN
        chk("irq asserted", {7'd0, irq_n}, 8'h00);
`else
        chk("irq tied", {7'd0, irq_n}, 8'h01);
`endif
        drive(0, 1,1,0, 2'd0, 8'h00, 0, 8'h00, 0); tick();
        drive(0, 0,0,0, 2'd1, 8'h00, 0, 8'h00, 0); tick();
        @(negedge clk);
        chk("irq released", {7'd0, irq_n}, 8'h01);
        chk("KBDCR after irq", dout, 8'h01);
        tick();

        // Reset during a pending display handshake with a key buffered
        drive(0, 1,1,1, 2'd2, 8'h78, 1, 8'h7A, 0); tick();
        drive(1, 0,0,0, 2'd0, 8'h00, 1, 8'h62, 1); tick();
        drive(0, 0,0,0, 2'd1, 8'h00, 0, 8'h00, 0);
        @(negedge clk);
        chk("rst KBDCR", dout, 8'h00);
        chk("rst kbd_ready", {7'd0, kbd_ready}, 8'h01);
        chk("rst dsp_valid", {7'd0, dsp_valid}, 8'h00);
        chk("rst dsp_data", dsp_data, 8'h00);
        chk("rst irq_n", {7'd0, irq_n}, 8'h01);
        addr = 2'd0; #1 chk("rst KBD", dout, 8'h00);
        addr = 2'd2; #1 chk("rst DSP", dout, 8'h00);
        addr = 2'd3; #1 chk("rst DSPCR", dout, 8'h00);
        tick();

        // Randomized traffic against the reference model
        drive(1, 0,0,0, 2'd0, 8'h00, 0, 8'h00, 0);
        m_reset();
        tick();
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 2) != 0),
                  8'($urandom_range(8'h40, 8'h7F)), ($urandom_range(0, 2) == 0));
            @(negedge clk);
            chk("rnd dout", dout, m_dout(addr));
            chk("rnd kbd_ready", {7'd0, kbd_ready}, {7'd0, (m_q.size() < DEPTH)});
            chk("rnd dsp_valid", {7'd0, dsp_valid}, {7'd0, m_dsp_valid});
            if (m_dsp_valid) chk("rnd dsp_data", dsp_data, {1'b0, m_dsp_char});
            chk("rnd irq_n", {7'd0, irq_n}, {7'd0, m_irq_n});
            m_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
